// File: rtl/lbm_pkg.sv
// Shared types for the LBM step sequencer: transfer phase tags, sequencer
// state encoding and the width of the optional stall counter.
package lbm_pkg;

  typedef enum logic [1:0] {
    PH_COLLIDE  = 2'd0,
    PH_STREAM   = 2'd1,
    PH_BOUNDARY = 2'd2,
    PH_NONE     = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLIDE,
    ST_STREAM,
    ST_BOUNDARY,
    ST_STEP_END,
    ST_DONE
  } seq_state_t;

  localparam int STALL_CNT_WIDTH = 16;

  // Phase tag presented to the datapath while in a given state.
  function automatic phase_t phase_of(input seq_state_t s);
    case (s)
      ST_COLLIDE:  return PH_COLLIDE;
      ST_STREAM:   return PH_STREAM;
      ST_BOUNDARY: return PH_BOUNDARY;
      default:     return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lbm_node_addr_counter.sv
// Wrapping lattice node counter 0..NUM_NODES-1. Clear has priority over
// Advance; Last flags the final node of a sweep.
module lbm_node_addr_counter #(
  parameter int NUM_NODES  = 64,
  parameter int ADDR_WIDTH = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic                  Advance,
  output logic [ADDR_WIDTH-1:0] Addr,
  output logic                  Last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);

  assign Last = (Addr == LAST_ADDR);

  // Node index: restart on Clear, step on each accepted transfer, wrap after the last node.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!Reset)       Addr <= '0;
    else if (Clear)   Addr <= '0;
    else if (Advance) Addr <= Last ? '0 : Addr + 1'b1;
  end

endmodule

// File: rtl/lbm_step_sequencer.sv
// LBM run sequencer: per time step sweeps every node through collide,
// stream and boundary, pulses Step_inc, and stops in DONE after MAX_TIME
// steps. Optional stall counter enabled by macro LBM_SEQ_STALL_CNT_EN.
// Outputs depend only on registered state; Node_ready never reaches an
// output combinationally.
module lbm_step_sequencer
  import lbm_pkg::*;
#(
  parameter int MAX_TIME         = 8,
  parameter int NUM_NODES        = 64,
  parameter int ADDR_WIDTH       = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Node_ready,
  output logic                        Node_valid,
  output logic [ADDR_WIDTH-1:0]       Node_addr,
  output phase_t                      Phase,
  output logic                        Step_inc,
  output logic [TIME_COUNT_WIDTH:0]   Time_step,
  output logic                        Busy,
  output logic                        Done
`ifdef LBM_SEQ_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0]  Stall_count
`endif
);

  localparam logic [TIME_COUNT_WIDTH:0] LAST_STEP = (TIME_COUNT_WIDTH + 1)'(MAX_TIME - 1);

  seq_state_t state, next_state;
  logic       transfer;
  logic       start_accept;
  logic       addr_last;

  assign transfer     = Node_valid && Node_ready;
  assign start_accept = Start && ((state == ST_IDLE) || (state == ST_DONE));

  lbm_node_addr_counter #(
    .NUM_NODES  (NUM_NODES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_counter (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clear   (start_accept),
    .Advance (transfer),
    .Addr    (Node_addr),
    .Last    (addr_last)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state: phases advance after the last node transfers; STEP_END lasts one cycle.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      ST_IDLE,
      ST_DONE:     if (Start) next_state = ST_COLLIDE;
      ST_COLLIDE:  if (transfer && addr_last) next_state = ST_STREAM;
      ST_STREAM:   if (transfer && addr_last) next_state = ST_BOUNDARY;
      ST_BOUNDARY: if (transfer && addr_last) next_state = ST_STEP_END;
      ST_STEP_END: next_state = (Time_step == LAST_STEP) ? ST_DONE : ST_COLLIDE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Output decode from state only.
  always_comb begin
    Node_valid = (state == ST_COLLIDE) || (state == ST_STREAM) || (state == ST_BOUNDARY);
    Phase      = phase_of(state);
    Step_inc   = (state == ST_STEP_END);
    Busy       = Node_valid || (state == ST_STEP_END);
    Done       = (state == ST_DONE);
  end

  // Completed-step count: cleared when a run starts, bumped on leaving STEP_END.
  // The FSM leaves for DONE at MAX_TIME, so the count never passes it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                   Time_step <= '0;
    else if (start_accept)        Time_step <= '0;
    else if (state == ST_STEP_END) Time_step <= Time_step + 1'b1;
  end

`ifdef LBM_SEQ_STALL_CNT_EN
  // Saturating count of cycles where a node is offered but not accepted.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                 Stall_count <= '0;
    else if (start_accept)      Stall_count <= '0;
    else if (Node_valid && !Node_ready && (Stall_count != '1))
                                Stall_count <= Stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Directed bench for lbm_step_sequencer: a 4-node/2-step instance for the
// main runs and a 1-node/1-step instance for the degenerate lattice.
module tb_lbm_step_sequencer;
  import lbm_pkg::*;

  localparam int NN = 4;
  localparam int MT = 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, Start, Node_ready;
  logic       Node_valid, Step_inc, Busy, Done;
  logic [1:0] Node_addr;
  phase_t     Phase;
  logic [1:0] Time_step;

  logic       start1, ready1;
  logic       nv1, si1, busy1, done1;
  logic [0:0] addr1;
  phase_t     phase1;
  logic [0:0] ts1;

`ifdef LBM_SEQ_STALL_CNT_EN
  logic [15:0] Stall_count, stall1;
`endif

  lbm_step_sequencer #(.MAX_TIME(MT), .NUM_NODES(NN)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Node_ready(Node_ready),
    .Node_valid(Node_valid), .Node_addr(Node_addr), .Phase(Phase),
    .Step_inc(Step_inc), .Time_step(Time_step), .Busy(Busy), .Done(Done)
`ifdef LBM_SEQ_STALL_CNT_EN
    , .Stall_count(Stall_count)
`endif
  );

  lbm_step_sequencer #(.MAX_TIME(1), .NUM_NODES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start1), .Node_ready(ready1),
    .Node_valid(nv1), .Node_addr(addr1), .Phase(phase1),
    .Step_inc(si1), .Time_step(ts1), .Busy(busy1), .Done(done1)
`ifdef LBM_SEQ_STALL_CNT_EN
    , .Stall_count(stall1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transfer monitor: expected address/phase sequence and Step_inc timing.
  int     cyc = 0;
  bit     mon_en = 1'b0;
  int     m_addr, xfers, steps;
  phase_t m_phase;
  int     step_cyc[4];

  always @(negedge Clk) begin
    cyc++;
    if (mon_en && Reset) begin
      if (Node_valid && Node_ready) begin
        check("xfer_addr", 32'(Node_addr), 32'(m_addr));
        check("xfer_phase", 32'(Phase), 32'(m_phase));
        xfers++;
        if (m_addr == NN - 1) begin
          m_addr = 0;
          case (m_phase)
            PH_COLLIDE: m_phase = PH_STREAM;
            PH_STREAM:  m_phase = PH_BOUNDARY;
            default:    m_phase = PH_COLLIDE;
          endcase
        end else begin
          m_addr++;
        end
      end
      if (Step_inc) begin
        if (steps < 4) step_cyc[steps] = cyc;
        steps++;
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic new_run;
    m_addr  = 0;
    m_phase = PH_COLLIDE;
    xfers   = 0;
    steps   = 0;
  endtask

  task automatic pulse_start;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!Done && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(Done), 32'd1);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_xfers"}, 32'(xfers), 32'd24);
    check({tag, "_steps"}, 32'(steps), 32'd2);
    check({tag, "_gap"}, 32'(step_cyc[1] - step_cyc[0]), 32'd13);
    check({tag, "_ts"}, 32'(Time_step), 32'd2);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int n;
    Reset = 1'b0; Start = 1'b0; Node_ready = 1'b1;
    start1 = 1'b0; ready1 = 1'b1;

    // Reset values
    #12;
    check("rst_valid", 32'(Node_valid), 32'd0);
    check("rst_addr", 32'(Node_addr), 32'd0);
    check("rst_phase", 32'(Phase), 32'(PH_NONE));
    check("rst_stepinc", 32'(Step_inc), 32'd0);
    check("rst_ts", 32'(Time_step), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Reset = 1'b1;
    tick();
    check("idle_hold", 32'(Busy), 32'd0);

    // Run 1: Node_ready always high
    new_run();
    mon_en = 1'b1;
    pulse_start();
    wait_done("run1");
    check_run("run1");

    // Run 2: restart from DONE, 3-cycle stall at COLLIDE addr 2
    new_run();
    pulse_start();
    check("restart_ts", 32'(Time_step), 32'd0);
    check("restart_done", 32'(Done), 32'd0);
    check("restart_busy", 32'(Busy), 32'd1);
    n = 0;
    while (!(Node_addr == 2'd2 && Phase == PH_COLLIDE) && n < 50) begin
      tick();
      n++;
    end
    check("stall_reach", 32'(Node_addr), 32'd2);
    Node_ready = 1'b0;
    repeat (3) begin
      tick();
      check("stall_addr", 32'(Node_addr), 32'd2);
      check("stall_phase", 32'(Phase), 32'(PH_COLLIDE));
      check("stall_valid", 32'(Node_valid), 32'd1);
    end
    Node_ready = 1'b1;
    wait_done("run2");
    check_run("run2");
`ifdef LBM_SEQ_STALL_CNT_EN
    check("run2_stalls", 32'(Stall_count), 32'd3);
`endif

    // Run 3: Start pulsed during STREAM of step 0 is ignored
    new_run();
    pulse_start();
    n = 0;
    while (Phase != PH_STREAM && n < 50) begin
      tick();
      n++;
    end
    check("s3_stream", 32'(Phase), 32'(PH_STREAM));
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("s3_ts", 32'(Time_step), 32'd0);
    wait_done("run3");
    check_run("run3");
`ifdef LBM_SEQ_STALL_CNT_EN
    check("run3_stalls", 32'(Stall_count), 32'd0);
`endif

    // Run 4: asynchronous reset mid-BOUNDARY of step 1, then a full run
    new_run();
    pulse_start();
    n = 0;
    while (!(Time_step == 2'd1 && Phase == PH_BOUNDARY) && n < 100) begin
      tick();
      n++;
    end
    check("r4_bnd", 32'(Phase), 32'(PH_BOUNDARY));
    tick();
    #2 Reset = 1'b0;
    #1;
    check("r4_valid", 32'(Node_valid), 32'd0);
    check("r4_ts", 32'(Time_step), 32'd0);
    check("r4_busy", 32'(Busy), 32'd0);
    check("r4_done", 32'(Done), 32'd0);
    check("r4_phase", 32'(Phase), 32'(PH_NONE));
    check("r4_addr", 32'(Node_addr), 32'd0);
    #3 Reset = 1'b1;
    tick();
    check("r4_idle", 32'(Busy), 32'd0);
    new_run();
    pulse_start();
    wait_done("run4");
    check_run("run4");

    // Single-node, single-step lattice
    mon_en = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("n1_c_valid", 32'(nv1), 32'd1);
    check("n1_c_addr", 32'(addr1), 32'd0);
    check("n1_c_phase", 32'(phase1), 32'(PH_COLLIDE));
    tick();
    check("n1_s_phase", 32'(phase1), 32'(PH_STREAM));
    check("n1_s_valid", 32'(nv1), 32'd1);
    tick();
    check("n1_b_phase", 32'(phase1), 32'(PH_BOUNDARY));
    check("n1_b_stepinc", 32'(si1), 32'd0);
    tick();
    check("n1_e_stepinc", 32'(si1), 32'd1);
    check("n1_e_valid", 32'(nv1), 32'd0);
    check("n1_e_done", 32'(done1), 32'd0);
    tick();
    check("n1_done", 32'(done1), 32'd1);
    check("n1_ts", 32'(ts1), 32'd1);
    check("n1_busy", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbm_step_sequencer.md
Name: lbm_step_sequencer

Overview:
- Drives one LBM simulation run: for each time step, sweeps every lattice node through the collide, stream and boundary phases.
- Issues node addresses to the compute datapath over a valid/ready handshake.
- Pulses Step_inc once per completed step. This is the Enable source for the time-step counter.
- Stops and flags Done after MAX_TIME steps.

Parameters:
- MAX_TIME, 8, number of time steps per run (must be >= 1).
- NUM_NODES, 64, lattice nodes swept per phase (must be >= 1).
- ADDR_WIDTH, $clog2(NUM_NODES), node address width (min 1).
- TIME_COUNT_WIDTH, $clog2(MAX_TIME), Time_step is TIME_COUNT_WIDTH+1 bits wide.

Ports:
- Clk  input  1  system clock; all state on posedge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 clears all state immediately).
- Start  input  1  begin run; sampled only in IDLE or DONE.
- Node_ready  input  1  datapath accepts the current node this cycle.
- Node_valid  output  1  Node_addr/Phase valid for transfer.
- Node_addr  output  ADDR_WIDTH  lattice node index.
- Phase  output  2  phase_t of current transfer.
- Step_inc  output  1  one-cycle pulse per completed step.
- Time_step  output  TIME_COUNT_WIDTH+1  completed steps in this run.
- Busy  output  1  high in COLLIDE/STREAM/BOUNDARY/STEP_END.
- Done  output  1  high in DONE.

Behaviour:
- Reset values: state IDLE, Node_valid 0, Node_addr 0, Phase PH_NONE, Step_inc 0, Time_step 0, Busy 0, Done 0.
- States: IDLE, COLLIDE, STREAM, BOUNDARY, STEP_END, DONE. All outputs are registered or decoded from state only; there is no combinational path from Node_ready to any output.
- IDLE: Start=1 -> COLLIDE with Node_addr=0. Otherwise hold.
- COLLIDE/STREAM/BOUNDARY:
  - Node_valid=1; Phase = PH_COLLIDE / PH_STREAM / PH_BOUNDARY respectively.
  - Transfer occurs when Node_valid && Node_ready.
  - On a transfer with Node_addr < NUM_NODES-1: Node_addr+1.
  - On a transfer with Node_addr == NUM_NODES-1: Node_addr <= 0 and advance to the next state (COLLIDE->STREAM->BOUNDARY->STEP_END).
  - Without a transfer, Node_addr and Phase hold stable.
  - Node_valid never drops mid-phase.
- STEP_END: exactly one cycle. Node_valid=0, Step_inc=1, Time_step+1. If the new value == MAX_TIME -> DONE, else -> COLLIDE.
- Throughput: with Node_ready held high, one step takes 3*NUM_NODES+1 cycles.
- DONE: Done=1, Busy=0, Time_step holds at MAX_TIME.
  - Start=1 -> Time_step <= 0, Done <= 0, -> COLLIDE with Node_addr=0.
  - Time_step never exceeds MAX_TIME.
- Start while Busy is ignored; it has no effect on addresses or counts.
- Reset asserted mid-run: immediate return to reset values. An in-flight node is dropped; the datapath must also be reset.
- Single-node lattice (NUM_NODES=1): each phase lasts one transfer.

Optional Feature:
- Macro LBM_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output Stall_count [15:0].
  - Counts cycles with Node_valid=1 && Node_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by Reset and when a run starts (Start accepted).
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package lbm_pkg holds:
  - typedef enum logic [1:0] phase_t {PH_COLLIDE=0, PH_STREAM=1, PH_BOUNDARY=2, PH_NONE=3};
  - seq_state_t state enum;
  - localparam STALL_CNT_WIDTH=16.
- One sub-module: lbm_node_addr_counter. Wrapping 0..NUM_NODES-1 counter with Clear, Advance and Last (addr==NUM_NODES-1) outputs; same asynchronous active-low reset.

Test Plan (MAX_TIME=2, NUM_NODES=4 unless noted):
- Start 1 cycle, Node_ready=1 always -> 24 transfers with addr sequence 0,1,2,3 per phase and phases C,S,B per step. Step_inc pulses twice, 13 cycles apart. Done=1 with Time_step=2.
- Node_ready=0 for 3 cycles at COLLIDE addr 2 -> Node_addr=2, Phase=PH_COLLIDE held stable for those cycles. With LBM_SEQ_STALL_CNT_EN: Stall_count=3 at end of run.
- Start pulsed during STREAM of step 0 -> no change: still exactly 2 Step_inc pulses and 24 transfers.
- Reset=0 asserted asynchronously mid-BOUNDARY of step 1 -> next sampled outputs: Node_valid=0, Time_step=0, Busy=0, state IDLE. Start after release -> full run from addr 0.
- In DONE, Start=1 -> Time_step clears to 0, Done drops next cycle, run repeats identically.
- NUM_NODES=1, MAX_TIME=1 -> transfers addr 0 with C, S, B on three consecutive cycles; Step_inc on the 4th; Done on the 5th.
